// File: rtl/pdu_dma_reader.sv
// pdu_dma_reader: single-descriptor DMA reader for the PDU ring buffer fetch port.
// Optional statistics counters are built when PDU_DMA_READER_STATS_EN is defined.
module pdu_dma_reader #(
  parameter int PDU_DEPTH     = 512,
  parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
  parameter int THRESHOLD     = 64,
  parameter int APP_IDX_WIDTH = 8,
  parameter int RD_LATENCY    = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dma_start,
  input  logic [PDU_AWIDTH-1:0]    dma_size,
  input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
  input  logic [APP_IDX_WIDTH-1:0] dma_queue,
  output logic                     dma_done,
  output logic [PDU_AWIDTH-1:0]    rd_addr,
  output logic                     rd_en,
  input  logic                     rd_valid,
  input  logic [511:0]             rd_data,
  output logic [511:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [APP_IDX_WIDTH-1:0] out_queue,
  output logic                     busy,
  output logic [31:0]              stat_flits,
  output logic [31:0]              stat_xfers
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(RD_LATENCY + 1);
  localparam logic [PDU_AWIDTH:0] MAX_SLOT = (PDU_AWIDTH+1)'(PDU_DEPTH - THRESHOLD);
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [1:0]               state_q, state_d;
  logic [PDU_AWIDTH-1:0]    ptr_q, ptr_d;
  logic [PDU_AWIDTH:0]      size_q, size_d, issued_q, issued_d, emitted_q, emitted_d;
  logic [PDU_AWIDTH:0]      ptr_inc;
  logic [APP_IDX_WIDTH-1:0] queue_q, queue_d;
  logic [CW-1:0]            in_flight_q, in_flight_d, cnt_q, cnt_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]            flush_q, flush_d;
  logic                     out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [511:0]             out_data_q, out_data_d;
  logic [511:0]             fifo_mem [FIFO_DEPTH];
  logic wr_in, accept, fifo_empty, load, pop, push, push_ok, credits_ok, rd_en_c;

  // Handshake, FIFO and credit qualifiers
  always_comb begin
    wr_in      = rd_valid && (flush_q == '0);
    accept     = out_valid_q && out_ready;
    fifo_empty = (cnt_q == '0);
    load       = (!out_valid_q || out_ready) && (!fifo_empty || wr_in);
    pop        = load && !fifo_empty;
    push       = wr_in && !(load && fifo_empty);
    push_ok    = push && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
    credits_ok = ({1'b0, in_flight_q} + {1'b0, cnt_q}) < CREDITS;
    rd_en_c    = (state_q == S_FETCH) && (issued_q < size_q) && credits_ok;
    ptr_inc    = {1'b0, ptr_q} + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    size_d      = size_q;
    issued_d    = issued_q;
    emitted_d   = emitted_q;
    queue_d     = queue_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    flush_d     = (flush_q != '0) ? flush_q - 1'b1 : flush_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    in_flight_d = in_flight_q;

    // Output stage loads from the FIFO head, or straight from the fetch port when empty
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_empty ? rd_data : fifo_mem[rd_ptr_q];
      out_sop_d   = (emitted_q == '0);
      out_eop_d   = (emitted_q == size_q - 1'b1);
      emitted_d   = emitted_q + 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push_ok) cnt_d = cnt_q - 1'b1;

    if (rd_en_c && !(wr_in && in_flight_q != '0))      in_flight_d = in_flight_q + 1'b1;
    else if (!rd_en_c && wr_in && in_flight_q != '0)   in_flight_d = in_flight_q - 1'b1;

    case (state_q)
      S_IDLE: if (dma_start) begin
        ptr_d     = dma_base_addr;
        size_d    = {1'b0, dma_size};
        queue_d   = dma_queue;
        issued_d  = '0;
        emitted_d = '0;
        state_d   = (dma_size == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: if (rd_en_c) begin
        ptr_d    = (ptr_inc >= MAX_SLOT) ? '0 : ptr_inc[PDU_AWIDTH-1:0];
        issued_d = issued_q + 1'b1;
        if (issued_q + 1'b1 == size_q) state_d = S_DRAIN;
      end
      S_DRAIN: if (accept && out_eop_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      size_q      <= '0;
      issued_q    <= '0;
      emitted_q   <= '0;
      queue_q     <= '0;
      in_flight_q <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flush_q     <= FW'(RD_LATENCY);
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      size_q      <= size_d;
      issued_q    <= issued_d;
      emitted_q   <= emitted_d;
      queue_q     <= queue_d;
      in_flight_q <= in_flight_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flush_q     <= flush_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
    out_data_q <= out_data_d;
    if (push_ok) fifo_mem[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !push_ok)) else $error("rd_valid with skid FIFO full: flit dropped");
      assert (!(dma_start && state_q != S_IDLE)) else $error("dma_start while busy ignored");
    end
  end

`ifdef PDU_DMA_READER_STATS_EN
  logic [31:0] stat_flits_q, stat_flits_d, stat_xfers_q, stat_xfers_d;
  always_comb begin
    stat_flits_d = stat_flits_q + (accept ? 32'd1 : 32'd0);
    stat_xfers_d = stat_xfers_q + ((state_q == S_DONE) ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits_q <= '0;
      stat_xfers_q <= '0;
    end else begin
      stat_flits_q <= stat_flits_d;
      stat_xfers_q <= stat_xfers_d;
    end
  end
  assign stat_flits = stat_flits_q;
  assign stat_xfers = stat_xfers_q;
`else
  assign stat_flits = '0;
  assign stat_xfers = '0;
`endif

  assign dma_done  = (state_q == S_DONE);
  assign rd_addr   = ptr_q;
  assign rd_en     = rd_en_c;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_queue = queue_q;
endmodule

// File: tb/tb_pdu_dma_reader.sv
// Directed bench for pdu_dma_reader with a 2-cycle ring-buffer fetch model.
module tb_pdu_dma_reader;
  localparam int AW = 9;
  localparam int MAXS = 448;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dma_start = 1'b0;
  logic [AW-1:0] dma_size = '0, dma_base_addr = '0;
  logic [7:0]   dma_queue = '0;
  logic         dma_done, rd_en, rd_valid, out_valid, out_sop, out_eop, busy;
  logic         out_ready = 1'b1;
  logic [AW-1:0] rd_addr;
  logic [511:0] rd_data, out_data;
  logic [7:0]   out_queue;
  logic [31:0]  stat_flits, stat_xfers;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  pdu_dma_reader dut (
    .clk(clk), .rst(rst), .dma_start(dma_start), .dma_size(dma_size),
    .dma_base_addr(dma_base_addr), .dma_queue(dma_queue), .dma_done(dma_done),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_queue(out_queue), .busy(busy),
    .stat_flits(stat_flits), .stat_xfers(stat_xfers)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] flit(input int a);
    flit = {16{32'hCAFE0000 | 32'(a)}};
  endfunction

  // Ring buffer fetch model: free-running, not reset, so late returns survive rst
  logic p1_v = 1'b0, p2_v = 1'b0;
  logic [AW-1:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    p1_v <= rd_en;  p1_a <= rd_addr;
    p2_v <= p1_v;   p2_a <= p1_a;
    cyc  <= cyc + 1;
    if (cyc > 20000) begin
      $display("FAIL global_timeout cycles=%0d limit=20000", cyc);
      $fatal(1, "timeout");
    end
  end
  assign rd_valid = p2_v;
  assign rd_data  = flit(int'(p2_a));

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int wrap_addr(input int base, input int idx);
    int a;
    a = base + idx;
    if (a >= MAXS) a -= MAXS;
    return a;
  endfunction

  // Called just after a negedge; k counts negedges after the one carrying dma_start
  task automatic run_xfer(input int base, input int size, input int q, input int stall,
                          input int exp_last, input string nm);
    int k, nissue, nacc, done_cnt, done_k, first_rd_k, first_ov_k, stall_left;
    int max_out, last_addr, addr_bad, data_bad, flag_bad, stable_bad, exp_addr;
    logic [511:0] hold;
    logic holding;
    nissue = 0; nacc = 0; done_cnt = 0; done_k = -1; first_rd_k = -1; first_ov_k = -1;
    stall_left = stall; max_out = 0; last_addr = -1; addr_bad = 0; data_bad = 0;
    flag_bad = 0; stable_bad = 0; exp_addr = base; holding = 1'b0; hold = '0;
    dma_base_addr = AW'(base); dma_size = AW'(size); dma_queue = 8'(q);
    dma_start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    k = 1;
    while (k <= 80) begin
      if (done_k >= 0 && k > done_k + 1) break;
      if (rd_en) begin
        if (first_rd_k < 0) first_rd_k = k;
        if (int'(rd_addr) != exp_addr) addr_bad++;
        last_addr = int'(rd_addr);
        nissue++;
        exp_addr = wrap_addr(exp_addr, 1);
      end
      if (dma_done) begin done_cnt++; done_k = k; end
      if (out_valid && first_ov_k < 0) first_ov_k = k;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        if (holding && out_data !== hold) stable_bad++;
        hold = out_data; holding = 1'b1;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (out_data !== flit(wrap_addr(base, nacc))) data_bad++;
        if (out_sop !== (nacc == 0) || out_eop !== (nacc == size - 1)) flag_bad++;
        if (int'(out_queue) != q) flag_bad++;
        nacc++;
      end
      if (nissue - nacc > max_out) max_out = nissue - nacc;
      @(negedge clk);
      k++;
    end
    check({nm, " flits_out"}, nacc, size);
    check({nm, " reads_issued"}, nissue, size);
    check({nm, " rd_addr_errors"}, addr_bad, 0);
    check({nm, " data_errors"}, data_bad, 0);
    check({nm, " sop_eop_queue_errors"}, flag_bad, 0);
    check({nm, " done_pulses"}, done_cnt, 1);
    check({nm, " busy_after"}, int'(busy), 0);
    check({nm, " out_valid_after"}, int'(out_valid), 0);
    if (size > 0) begin
      check({nm, " first_rd_en_cycle"}, first_rd_k, 1);
      check({nm, " first_out_valid_cycle"}, first_ov_k, 4);
      check({nm, " last_rd_addr"}, last_addr, exp_last);
      check({nm, " done_not_before_5"}, int'(done_k >= 5), 1);
    end else begin
      check({nm, " done_within_2"}, int'(done_k >= 1 && done_k <= 2), 1);
      check({nm, " no_out_valid"}, first_ov_k, -1);
    end
    if (stall > 0) begin
      check({nm, " stall_data_stable_errors"}, stable_bad, 0);
      check({nm, " outstanding_within_credit"}, int'(max_out <= 5), 1);
    end
  endtask

  typedef struct {
    int base;
    int size;
    int q;
    int stall;
    int exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int acc;
    vecs[0] = '{base: 0,   size: 4, q: 3,  stall: 0, exp_last: 3};
    vecs[1] = '{base: 446, size: 4, q: 7,  stall: 0, exp_last: 1};
    vecs[2] = '{base: 10,  size: 1, q: 1,  stall: 0, exp_last: 10};
    vecs[3] = '{base: 20,  size: 8, q: 9,  stall: 6, exp_last: 27};
    vecs[4] = '{base: 5,   size: 0, q: 2,  stall: 0, exp_last: 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset dma_done", int'(dma_done), 0);
    check("reset rd_en", int'(rd_en), 0);
    check("reset out_valid_sop_eop", int'({out_valid, out_sop, out_eop}), 0);
    check("reset busy", int'(busy), 0);
    check("reset rd_addr", int'(rd_addr), 0);
    check("reset out_queue", int'(out_queue), 0);
    check("reset stats", int'(stat_flits | stat_xfers), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].base, vecs[i].size, vecs[i].q, vecs[i].stall, vecs[i].exp_last,
               $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Reset after three accepted flits of an 8-flit transfer, then restart at once
    dma_base_addr = AW'(40); dma_size = AW'(8); dma_queue = 8'd5;
    dma_start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    acc = 0;
    for (int k = 0; k < 40 && acc < 3; k++) begin
      if (out_valid && out_ready) acc++;
      @(negedge clk);
    end
    check("midrst flits_before_reset", acc, 3);
    check("midrst busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy_after_reset", int'(busy), 0);
    check("midrst out_valid_after_reset", int'(out_valid), 0);
    run_xfer(100, 2, 6, 0, 101, "post_reset");
`ifdef PDU_DMA_READER_STATS_EN
    check("stat_xfers", int'(stat_xfers), 1);
    check("stat_flits", int'(stat_flits), 2);
`else
    check("stat_xfers_tied", int'(stat_xfers), 0);
    check("stat_flits_tied", int'(stat_flits), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
